// File: rtl/count_sampler.sv
// count_sampler
//   Captures the rippling output of a 4-bit JK ripple counter into the clk
//   domain. A code is accepted only after it has been seen on two consecutive
//   samples. Accepted values are extended with a wrap counter into a wide
//   event count, and single-cycle step / wrap / match pulses are produced.
//
// Ports
//   clk        system clock, rising edge
//   clear      synchronous active-high reset, overrides every other event
//   count_in   ripple counter output, may be mid-ripple when sampled
//   threshold  compare value for match, sampled on the acceptance edge
//   count_q    last accepted (stable) count value
//   ext_count  {wrap_cnt, count_q}
//   step       one-cycle pulse: count_q just changed
//   wrap       one-cycle pulse: accepted value decreased
//   match      one-cycle pulse: newly accepted value equals threshold
//   ovf        sticky: wrap counter rolled over from all-ones to zero
module count_sampler #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [3:0]        count_in,
  input  logic [3:0]        threshold,
  output logic [3:0]        count_q,
  output logic [WRAP_W+3:0] ext_count,
  output logic              step,
  output logic              wrap,
  output logic              match,
  output logic              ovf
);

  logic [3:0]        samp_p1;
  logic [3:0]        samp_p2;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              accept;
  logic              decrease;

  // Any decrease is one wrap: 15->0, an upstream clear, or a skipped code.
  assign accept    = (samp_p1 == samp_p2) && (samp_p2 != count_q);
  assign decrease  = (samp_p2 < count_q);
  assign ext_count = {wrap_cnt, count_q};

  always_ff @(posedge clk) begin
    if (clear) begin
      samp_p1  <= '0;
      samp_p2  <= '0;
      count_q  <= '0;
      wrap_cnt <= '0;
      step     <= 1'b0;
      wrap     <= 1'b0;
      match    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      // stage p1/p2: two-flop sample of the asynchronous ripple bus
      samp_p1 <= count_in;
      samp_p2 <= samp_p1;

      // acceptance stage: pulses are rewritten every edge, never stretched
      step  <= accept;
      wrap  <= accept && decrease;
      match <= accept && (samp_p2 == threshold);

      if (accept) begin
        count_q <= samp_p2;
        if (decrease) begin
          wrap_cnt <= wrap_cnt + 1'b1;
          if (&wrap_cnt) begin
            ovf <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_count_sampler.sv
module tb_count_sampler;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [3:0]  count_in = 4'h0;
  logic [3:0]  threshold = 4'h0;
  logic [3:0]  count_q;
  logic [11:0] ext_count;
  logic        step, wrap, match, ovf;

  count_sampler #(.WRAP_W(8)) dut (
    .clk(clk), .clear(clear), .count_in(count_in), .threshold(threshold),
    .count_q(count_q), .ext_count(ext_count), .step(step), .wrap(wrap),
    .match(match), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [3:0]  q;
    logic [11:0] ext;
    logic        w;
    logic        m;
    logic        o;
  } exp_t;
  exp_t sbq[$];

  // Reference model: a code counts as seen once it occupied two consecutive
  // sampled edges; the total number of decreases is kept as a plain integer.
  int acc = 0;
  int wraps = 0;
  int hist[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input int v, input int thr, input bit clr);
    exp_t e;
    int a, b;
    if (clr) begin
      acc = 0;
      wraps = 0;
      hist.delete();
      hist.push_back(0);
      hist.push_back(0);
    end else begin
      a = hist[hist.size()-2];
      b = hist[hist.size()-1];
      if (a == b && b != acc) begin
        e.w = (b < acc);
        if (b < acc) wraps++;
        acc = b;
        e.q = 4'(b);
        e.ext = 12'(((wraps % 256) * 16) + b);
        e.m = (b == thr);
        e.o = (wraps >= 256);
        sbq.push_back(e);
      end
      hist.push_back(v);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  endtask

  task automatic cyc(input logic [3:0] v, input logic [3:0] t, input logic c);
    @(negedge clk);
    count_in = v;
    threshold = t;
    clear = c;
    @(posedge clk);
    model(int'(v), int'(t), c);
  endtask

  task automatic hold(input logic [3:0] v, input int n, input logic [3:0] t);
    for (int i = 0; i < n; i++) cyc(v, t, 1'b0);
  endtask

  // Monitor: pops one expectation per observed step pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (step === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_step: got count_q=%0h expected no step", count_q);
        end else begin
          e = sbq.pop_front();
          chk("sb_count_q", 32'(count_q), 32'(e.q));
          chk("sb_ext_count", 32'(ext_count), 32'(e.ext));
          chk("sb_wrap", 32'(wrap), 32'(e.w));
          chk("sb_match", 32'(match), 32'(e.m));
          chk("sb_ovf", 32'(ovf), 32'(e.o));
        end
      end else begin
        chk("idle_wrap", 32'(wrap), 32'(1'b0));
        chk("idle_match", 32'(match), 32'(1'b0));
      end
    end
  end

  initial begin
    // reset with 0xA present, then release
    cyc(4'hA, 4'h0, 1'b1);
    mon_en = 1'b1;
    cyc(4'hA, 4'h0, 1'b1);
    #1;
    chk("rst_count_q", 32'(count_q), 0);
    chk("rst_ext_count", 32'(ext_count), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_ovf", 32'(ovf), 0);
    cyc(4'hA, 4'h0, 1'b0);
    cyc(4'hA, 4'h0, 1'b0);
    #1 chk("rel_no_step_early", 32'(step), 0);
    cyc(4'hA, 4'h0, 1'b0);
    #1;
    chk("rel_step", 32'(step), 1);
    chk("rel_count_q", 32'(count_q), 32'h A);
    chk("rel_wrap", 32'(wrap), 0);
    hold(4'hA, 2, 4'h0);

    // latency: 0 then 1 before E0
    cyc(4'h0, 4'h0, 1'b1);
    hold(4'h0, 3, 4'h0);
    cyc(4'h1, 4'h0, 1'b0);
    #1 chk("lat_e0_step", 32'(step), 0);
    cyc(4'h1, 4'h0, 1'b0);
    #1 chk("lat_e1_step", 32'(step), 0);
    cyc(4'h1, 4'h0, 1'b0);
    #1;
    chk("lat_e2_step", 32'(step), 1);
    chk("lat_count_q", 32'(count_q), 1);
    chk("lat_ext_count", 32'(ext_count), 1);
    cyc(4'h1, 4'h0, 1'b0);
    #1 chk("lat_pulse_one_cycle", 32'(step), 0);

    // glitch: 3, 7 for one cycle, 4 held
    hold(4'h3, 3, 4'h0);
    hold(4'h7, 1, 4'h0);
    hold(4'h4, 4, 4'h0);
    #1 chk("glitch_count_q", 32'(count_q), 4);

    // wrap and match from a fresh state
    cyc(4'h0, 4'h0, 1'b1);
    hold(4'hE, 3, 4'h0);
    hold(4'hF, 3, 4'h0);
    #1 chk("wm_ext_before", 32'(ext_count), 32'h00F);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    #1;
    chk("wm_step", 32'(step), 1);
    chk("wm_wrap", 32'(wrap), 1);
    chk("wm_match", 32'(match), 1);
    chk("wm_ext_after", 32'(ext_count), 32'h010);

    // overflow: 256 wraps from a fresh state
    cyc(4'h0, 4'h0, 1'b1);
    for (int s = 0; s < 256; s++)
      for (int v = 0; v < 16; v++) hold(4'(v), 2, 4'h5);
    hold(4'h0, 3, 4'h5);
    #1;
    chk("ovf_wrap_cnt_zero", 32'(ext_count[11:4]), 0);
    chk("ovf_set", 32'(ovf), 1);
    hold(4'h3, 4, 4'h5);
    #1 chk("ovf_sticky", 32'(ovf), 1);
    cyc(4'h3, 4'h5, 1'b1);
    #1;
    chk("ovf_cleared", 32'(ovf), 0);
    chk("ovf_ext_cleared", 32'(ext_count), 0);

    // clear on the edge of a pending acceptance (s1==s2=5, count_q=4)
    hold(4'h4, 4, 4'h0);
    hold(4'h5, 2, 4'h0);
    cyc(4'h5, 4'h0, 1'b1);
    #1;
    chk("midclr_step", 32'(step), 0);
    chk("midclr_count_q", 32'(count_q), 0);
    hold(4'h5, 3, 4'h0);
    #1;
    chk("midclr_accept_step", 32'(step), 1);
    chk("midclr_accept_q", 32'(count_q), 5);

    // randomized traffic, occasional clear, 1..3 cycle holds
    for (int i = 0; i < 1200; i++) begin
      logic [3:0] v, t;
      v = 4'($urandom_range(0, 15));
      t = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) cyc(v, t, 1'b1);
      else hold(v, int'($urandom_range(1, 3)), t);
    end
    hold(count_in, 4, threshold);
    #1;
    chk("final_ext_count", 32'(ext_count), 32'(((wraps % 256) * 16) + acc));
    chk("final_ovf", 32'(ovf), 32'(wraps >= 256));
    chk("sb_drained", 32'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_sampler.md
# count_sampler

Synchronous capture stage placed directly downstream of the 4-bit JK ripple counter. It samples the counter's rippling `count` bus into the `clk` domain and rejects transient codes with a two-sample stability filter. It extends the 4-bit value with a wrap counter into a wide event count and emits single-cycle step, wrap and threshold-match pulses for downstream control logic.

## Interface
Parameters:
- `WRAP_W`, default 8: width of the wrap (overflow-extension) counter.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `clear`  in  1  reset, synchronous, active-high.
- `count_in`  in  4  ripple counter output; may be mid-ripple when sampled.
- `threshold`  in  4  compare value for `match`; sampled on the acceptance edge.
- `count_q`  out  4  last accepted (stable) count value.
- `ext_count`  out  WRAP_W+4  `{wrap_cnt, count_q}`.
- `step`  out  1  one-cycle pulse: `count_q` just changed.
- `wrap`  out  1  one-cycle pulse: accepted value decreased (counter wrapped or was cleared).
- `match`  out  1  one-cycle pulse: newly accepted value equals `threshold`.
- `ovf`  out  1  sticky: `wrap_cnt` rolled over from all-ones to 0.

## Operation
- Sample pipeline: `s1 <= count_in`, `s2 <= s1` on every edge.
- Stability filter: a sample is stable when `s1 == s2`.
- Acceptance: on an edge where the sample is stable and `s2 != count_q`:
  - `count_q <= s2`
  - `step <= 1`
  - `match <= (s2 == threshold)`
  - if `s2 < count_q`: `wrap <= 1` and `wrap_cnt <= wrap_cnt + 1` (mod 2^WRAP_W)
  - if `wrap_cnt` is all-ones at that wrap: `ovf <= 1`
- On every edge without an acceptance, `step`, `wrap` and `match` return to 0.
- Pulses are never stretched. Back-to-back acceptances produce back-to-back pulses.
- Any decrease counts as a wrap. This covers 15→0 and also an upstream clear to 0; a skipped code (e.g. 14→1) is still one wrap.
- Forward multi-step jumps (e.g. 3→6) produce a single `step`. There is no interpolation.
- `ovf` stays at 1 until `clear`.
- No state machine beyond the pipeline. Implicit states: IDLE (stable, equal to `count_q`), SETTLING (`s1 != s2`), ACCEPT (single edge).

## Timing
- Reset: on an edge with `clear=1`, `s1`, `s2`, `count_q` and `wrap_cnt` become 0, and `step`, `wrap`, `match` and `ovf` become 0. `clear` overrides every simultaneous event.
- First edge after `clear` deasserts: normal sampling resumes. A nonzero `count_in` present at release is accepted 2 edges later with a `step`, and without a `wrap`.
- Latency: `count_in` settles before edge E0. `s1` loads at E0 and `s2` at E1. Acceptance happens at E2, so `count_q`, `ext_count` and pulses are valid in the cycle after E2: 3 edges counting E0.
- Glitch rejection: a code held for exactly 1 cycle is never accepted. A code held for 2 or more cycles is always accepted.
- Maximum tracked rate: the input must change no faster than once every 2 `clk` cycles for every code to be seen.
- `ext_count` updates atomically: `count_q` and `wrap_cnt` change on the same edge.

## Test plan
- Reset: drive `clear=1` for 2 cycles with `count_in=4'hA` → all outputs 0. Release `clear` → `count_q=4'hA` and `step=1` for 1 cycle at the 3rd edge after release, with `wrap=0`.
- Latency: hold 0, then set `count_in=1` before edge E0 → `step=1` only in the cycle after E2, `count_q=1`, `ext_count=1`.
- Glitch: sequence 3, 7 (1 cycle), 4 held → no acceptance of 7. `count_q` goes 3→4 with exactly one `step`.
- Wrap and match: `threshold=0`, step 14, 15, 0 (each held 3 cycles) → on the 0 acceptance `step=wrap=match=1` together, and `ext_count` goes from 0x00F to 0x010.
- Overflow: with `WRAP_W=8`, drive 256 full 0..15 sweeps → `wrap_cnt` returns to 0 and `ovf=1` stays high. A subsequent `clear` zeroes it.
- Reset mid-operation: assert `clear` on the same edge as a pending acceptance (`s1==s2=5`, `count_q=4`) → no pulses, `count_q=0`. Release `clear` → 5 is accepted 2 edges later.
